// File: rtl/bus_pkg.sv
// bus_pkg: bus source/destination ids and the transfer sequencer state encoding
package bus_pkg;
  localparam int SRC_R0 = 0, SRC_R1 = 1, SRC_R2 = 2, SRC_R3 = 3, SRC_R4 = 4, SRC_R5 = 5;
  localparam int SRC_R6 = 6, SRC_R7 = 7, SRC_R8 = 8, SRC_R9 = 9, SRC_R10 = 10, SRC_R11 = 11;
  localparam int SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
  localparam int SRC_HI = 16, SRC_LO = 17, SRC_ZHI = 18, SRC_ZLO = 19;
  localparam int SRC_PC = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_C = 23;
  localparam int DST_R0 = 0, DST_R1 = 1, DST_R2 = 2, DST_R3 = 3, DST_R4 = 4, DST_R5 = 5;
  localparam int DST_R6 = 6, DST_R7 = 7, DST_R8 = 8, DST_R9 = 9, DST_R10 = 10, DST_R11 = 11;
  localparam int DST_R12 = 12, DST_R13 = 13, DST_R14 = 14, DST_R15 = 15;
  localparam int DST_HI = 16, DST_LO = 17, DST_Y = 18, DST_Z = 19;
  localparam int DST_PC = 20, DST_MDR = 21, DST_MAR = 22, DST_IR = 23;
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH} xfer_state_e;
endpackage

// File: rtl/bus_xfer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker scanning upward from ptr with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW-1:0] j;
  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!valid && req[j] && !mask[j]) begin
        valid  = 1'b1;
        win[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/bus_xfer_arbiter.sv
// bus_xfer_arbiter: round-robin sequencer of source->destination transfers over the shared bus
// Define BUS_XFER_PRIO_EN to give requester 0 fixed highest priority.
module bus_xfer_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_SRC = 24,
  parameter int NUM_DST = 24,
  parameter int ID_W    = 5
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*ID_W-1:0] req_src,
  input  logic [NUM_REQ*ID_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_SRC-1:0]      src_out_en,
  output logic [NUM_DST-1:0]      dst_in_en,
  output logic                    busy,
  output logic                    err_bad_id
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  xfer_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, rr_idx, pick_idx;
  logic [ID_W-1:0] src_id_q, src_id_d, dst_id_q, dst_id_d, sel_src, sel_dst;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, mask, rr_req, rr_win, pick_win;
  logic [NUM_SRC-1:0] src_en_q, src_en_d;
  logic [NUM_DST-1:0] dst_en_q, dst_en_d;
  logic busy_q, busy_d, err_q, err_d, rr_valid, pick_valid, keep_ptr, bad;
  // the owner finishing in LATCH may not win the overlapping arbitration
  assign mask = state_q == LATCH ? grant_q : '0;
`ifdef BUS_XFER_PRIO_EN
  logic prio0;
  assign prio0      = req[0] & ~mask[0];
  assign rr_req     = req & ~NUM_REQ'(1);
  assign pick_win   = prio0 ? NUM_REQ'(1) : rr_win;
  assign pick_idx   = prio0 ? '0 : rr_idx;
  assign pick_valid = prio0 | rr_valid;
  assign keep_ptr   = prio0;
`else
  assign rr_req     = req;
  assign pick_win   = rr_win;
  assign pick_idx   = rr_idx;
  assign pick_valid = rr_valid;
  assign keep_ptr   = 1'b0;
`endif
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req  (rr_req),
    .mask (mask),
    .ptr  (ptr_q),
    .win  (rr_win),
    .idx  (rr_idx),
    .valid(rr_valid)
  );
  assign sel_src = req_src[int'(pick_idx)*ID_W +: ID_W];
  assign sel_dst = req_dst[int'(pick_idx)*ID_W +: ID_W];
  assign bad     = int'(sel_src) >= NUM_SRC || int'(sel_dst) >= NUM_DST;
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    src_id_d = src_id_q;
    dst_id_d = dst_id_q;
    done_d   = '0;
    src_en_d = '0;
    dst_en_d = '0;
    busy_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q == DRIVE) begin
      state_d  = LATCH;
      src_en_d = NUM_SRC'(1) << src_id_q;
      dst_en_d = NUM_DST'(1) << dst_id_q;
      done_d   = grant_q;
      busy_d   = 1'b1;
    end else if (pick_valid) begin
      state_d  = bad ? LATCH : DRIVE;
      grant_d  = pick_win;
      src_id_d = sel_src;
      dst_id_d = sel_dst;
      ptr_d    = keep_ptr ? ptr_q : (pick_idx == PW'(NUM_REQ - 1) ? '0 : pick_idx + PW'(1));
      src_en_d = bad ? '0 : NUM_SRC'(1) << sel_src;
      done_d   = bad ? pick_win : '0;
      err_d    = bad;
      busy_d   = 1'b1;
    end else if (state_q == LATCH) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      src_id_q <= '0;
      dst_id_q <= '0;
      done_q   <= '0;
      src_en_q <= '0;
      dst_en_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      src_id_q <= src_id_d;
      dst_id_q <= dst_id_d;
      done_q   <= done_d;
      src_en_q <= src_en_d;
      dst_en_q <= dst_en_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end
  assign grant      = grant_q;
  assign done       = done_q;
  assign src_out_en = src_en_q;
  assign dst_in_en  = dst_en_q;
  assign busy       = busy_q;
  assign err_bad_id = err_q;
endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// tb_bus_xfer_arbiter: directed scoreboard bench for the bus transfer arbiter
module tb_bus_xfer_arbiter;
  import bus_pkg::*;
  logic clock = 1'b0;
  logic clear;
  logic [3:0] req;
  logic [19:0] req_src, req_dst;
  logic [3:0] grant, done;
  logic [23:0] src_out_en, dst_in_en;
  logic busy, err_bad_id;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [3:0]  g;
    logic [3:0]  d;
    logic [23:0] s;
    logic [23:0] t;
    logic        b;
    logic        e;
  } obs_t;
  obs_t exp_q[$];
  string tag_q[$];
`ifdef BUS_XFER_PRIO_EN
  int cont_seq [5] = '{0, 1, 0, 2, 0};
`else
  int cont_seq [5] = '{0, 1, 2, 3, 0};
`endif
  always #5 clock = ~clock;
  bus_xfer_arbiter dut (
    .clock(clock), .clear(clear), .req(req), .req_src(req_src), .req_dst(req_dst),
    .grant(grant), .done(done), .src_out_en(src_out_en), .dst_in_en(dst_in_en),
    .busy(busy), .err_bad_id(err_bad_id)
  );
  function automatic logic [23:0] oh(input int id);
    oh = 24'(1) << id;
  endfunction
  task automatic set_ids(input int i, input int s, input int d);
    req_src[i*5 +: 5] = 5'(s);
    req_dst[i*5 +: 5] = 5'(d);
  endtask
  task automatic cyc(input string tag, input logic [3:0] g, input logic [3:0] d,
                     input logic [23:0] s, input logic [23:0] t, input logic b, input logic e);
    obs_t o, x;
    string tg;
    exp_q.push_back({g, d, s, t, b, e});
    tag_q.push_back(tag);
    @(posedge clock);
    @(negedge clock);
    o  = {grant, done, src_out_en, dst_in_en, busy, err_bad_id};
    x  = exp_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: got g=%b d=%b src=%h dst=%h busy=%b err=%b, expected g=%b d=%b src=%h dst=%h busy=%b err=%b",
             tg, o.g, o.d, o.s, o.t, o.b, o.e, x.g, x.d, x.s, x.t, x.b, x.e);
    end
  endtask
  task automatic idle(input string tag);
    cyc(tag, 4'b0, 4'b0, 24'b0, 24'b0, 1'b0, 1'b0);
  endtask
  initial begin
    logic [3:0] g;
    clear = 1'b0;
    req   = 4'hf;
    for (int i = 0; i < 4; i++) set_ids(i, i + 1, i + 8);
    idle("rst0");
    idle("rst1");
    clear = 1'b1;
    req   = 4'h0;
    idle("idle0");
    req = 4'hf;
    for (int k = 0; k < 5; k++) begin
      g = 4'(1) << cont_seq[k];
      cyc("c_drive", g, 4'b0, oh(cont_seq[k] + 1), 24'b0, 1'b1, 1'b0);
      if (k == 4) req = 4'h0;
      cyc("c_latch", g, g, oh(cont_seq[k] + 1), oh(cont_seq[k] + 8), 1'b1, 1'b0);
    end
    idle("c_idle");
    set_ids(1, SRC_PC, DST_R5);
    req = 4'b0010;
    cyc("s_drive", 4'b0010, 4'b0, oh(SRC_PC), 24'b0, 1'b1, 1'b0);
    req = 4'b0000;
    set_ids(1, 3, 7);
    cyc("s_latch", 4'b0010, 4'b0010, oh(SRC_PC), oh(DST_R5), 1'b1, 1'b0);
    idle("s_idle");
    set_ids(2, 30, 9);
    req = 4'b1110;
    cyc("b_reject", 4'b0100, 4'b0100, 24'b0, 24'b0, 1'b1, 1'b1);
    cyc("b_next", 4'b1000, 4'b0, oh(4), 24'b0, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("b_latch", 4'b1000, 4'b1000, oh(4), oh(11), 1'b1, 1'b0);
    idle("b_idle");
    set_ids(0, 1, 24);
    req = 4'b0001;
    cyc("b_dst", 4'b0001, 4'b0001, 24'b0, 24'b0, 1'b1, 1'b1);
    req = 4'b0000;
    idle("b_dst_idle");
    set_ids(0, 1, 8);
    set_ids(2, 3, 10);
    req = 4'b0001;
    cyc("r_drive", 4'b0001, 4'b0, oh(1), 24'b0, 1'b1, 1'b0);
    clear = 1'b0;
    idle("r_abort");
    clear = 1'b1;
    req   = 4'b0011;
    cyc("r_ptr", 4'b0001, 4'b0, oh(1), 24'b0, 1'b1, 1'b0);
    cyc("r_latch0", 4'b0001, 4'b0001, oh(1), oh(8), 1'b1, 1'b0);
    cyc("r_b2b", 4'b0010, 4'b0, oh(3), 24'b0, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("r_latch1", 4'b0010, 4'b0010, oh(3), oh(7), 1'b1, 1'b0);
    idle("r_idle");
    req = 4'b0001;
    cyc("h_drive", 4'b0001, 4'b0, oh(1), 24'b0, 1'b1, 1'b0);
    cyc("h_latch", 4'b0001, 4'b0001, oh(1), oh(8), 1'b1, 1'b0);
    idle("h_gap");
    cyc("h_again", 4'b0001, 4'b0, oh(1), 24'b0, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("h_latch2", 4'b0001, 4'b0001, oh(1), oh(8), 1'b1, 1'b0);
    idle("h_idle");
`ifdef BUS_XFER_PRIO_EN
    req = 4'b1110;
    cyc("p_drive", 4'b0100, 4'b0, oh(3), 24'b0, 1'b1, 1'b0);
    cyc("p_latch", 4'b0100, 4'b0100, oh(3), oh(10), 1'b1, 1'b0);
    req = 4'b1111;
    cyc("p_win0", 4'b0001, 4'b0, oh(1), 24'b0, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("p_latch0", 4'b0001, 4'b0001, oh(1), oh(8), 1'b1, 1'b0);
    idle("p_idle");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
